// File: rtl/aes_pkg.sv
// Shared AES constants and the round-controller FSM encoding.
package aes_pkg;

  localparam int AES_ROUNDS_128  = 10;
  localparam int AES_ROUNDS_256  = 14;
  localparam int AES_BLOCK_WIDTH = 128;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_KEY_WAIT = 2'd1,
    ST_ROUND    = 2'd2,
    ST_DONE     = 2'd3
  } aes_state_e;

endpackage

// File: rtl/aes_round_controller_if.sv
// Host, round-key memory, round-function and ciphertext signals of the round controller.
interface aes_round_controller_if
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH     = AES_BLOCK_WIDTH,
  parameter int KEY_WIDTH      = AES_BLOCK_WIDTH,
  parameter int KEY_ADDR_WIDTH = 4
);
  logic                      start_valid_in;
  logic                      start_ready_out;
  logic [DATA_WIDTH-1:0]     data_in;
  logic                      abort_in;
  logic                      key_rd_en_out;
  logic [KEY_ADDR_WIDTH-1:0] key_addr_out;
  logic [KEY_WIDTH-1:0]      key_in;
  logic                      round_valid_out;
  logic                      round_last_out;
  logic [DATA_WIDTH-1:0]     round_data_out;
  logic                      round_valid_in;
  logic [DATA_WIDTH-1:0]     round_data_in;
  logic                      valid_out;
  logic [DATA_WIDTH-1:0]     data_out;
  logic                      ready_in;
  logic                      busy_out;

  // Controller side.
  modport slave (
    input  start_valid_in, data_in, abort_in, key_in, round_valid_in, round_data_in, ready_in,
    output start_ready_out, key_rd_en_out, key_addr_out, round_valid_out, round_last_out,
           round_data_out, valid_out, data_out, busy_out
  );

  // Host / key memory / round-function side.
  modport master (
    output start_valid_in, data_in, abort_in, key_in, round_valid_in, round_data_in, ready_in,
    input  start_ready_out, key_rd_en_out, key_addr_out, round_valid_out, round_last_out,
           round_data_out, valid_out, data_out, busy_out
  );
endinterface

// File: rtl/addRoundKey.sv
// addRoundKey: byte-lane XOR of state and round key, purely combinational.
module addRoundKey #(
  parameter int DATA_WIDTH = 128
) (
  input  logic [DATA_WIDTH-1:0] state_i,
  input  logic [DATA_WIDTH-1:0] key_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] state_o,
  output logic                  valid_o
);
  localparam int NUM_LANES = DATA_WIDTH / 8;

  logic [NUM_LANES-1:0][7:0] st_l, key_l, out_l;

  assign st_l  = state_i;
  assign key_l = key_i;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign out_l[g] = st_l[g] ^ key_l[g];
  end

  assign state_o = out_l;
  assign valid_o = valid_i;
endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-encrypt sequencer: fetches round keys, drives an external round
// function and applies addRoundKey until NUM_ROUNDS is reached.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int DATA_WIDTH     = AES_BLOCK_WIDTH,
  parameter int KEY_WIDTH      = AES_BLOCK_WIDTH,
  parameter int NUM_ROUNDS     = AES_ROUNDS_128,
  parameter int KEY_ADDR_WIDTH = 4
) (
  input logic                   clk,
  input logic                   reset_n,
  aes_round_controller_if.slave bus
);
  localparam logic [KEY_ADDR_WIDTH-1:0] LAST_RND = KEY_ADDR_WIDTH'(NUM_ROUNDS);

  aes_state_e                fsm_q, fsm_d;
  logic [KEY_ADDR_WIDTH-1:0] cnt_q, cnt_d, addr_q, addr_d, key_addr;
  logic [DATA_WIDTH-1:0]     pt_q, pt_d, res_q, res_d, st_q, st_d, ark_op, ark_out;
  logic [KEY_WIDTH-1:0]      rkey;
  logic                      accept, rnd_take, last_rnd, ark_vld, key_rd;

  assign last_rnd = (cnt_q == LAST_RND);
  // abort_in outranks every other handshake in the same cycle
  assign accept   = (fsm_q == ST_IDLE)  && bus.start_valid_in && !bus.abort_in;
  assign rnd_take = (fsm_q == ST_ROUND) && bus.round_valid_in && !bus.abort_in;
  assign rkey     = bus.key_in;
  assign ark_op   = (cnt_q == '0) ? pt_q : res_q;

  addRoundKey #(.DATA_WIDTH(DATA_WIDTH)) u_ark (
    .state_i (ark_op),
    .key_i   (rkey),
    .valid_i (1'b1),
    .state_o (ark_out),
    .valid_o (ark_vld)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fsm_q <= ST_IDLE;
    else          fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    if (fsm_q != ST_IDLE && bus.abort_in) fsm_d = ST_IDLE;
    else begin
      case (fsm_q)
        ST_IDLE:     if (accept) fsm_d = ST_KEY_WAIT;
        ST_KEY_WAIT: fsm_d = last_rnd ? ST_DONE : ST_ROUND;
        ST_ROUND:    if (bus.round_valid_in) fsm_d = ST_KEY_WAIT;
        ST_DONE:     if (bus.ready_in) fsm_d = ST_IDLE;
        default:     fsm_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    key_rd   = accept || rnd_take;
    key_addr = addr_q;
    if (accept)        key_addr = '0;
    else if (rnd_take) key_addr = cnt_q;
    bus.key_rd_en_out   = key_rd;
    bus.key_addr_out    = key_addr;
    bus.start_ready_out = (fsm_q == ST_IDLE);
    bus.busy_out        = (fsm_q != ST_IDLE);
    bus.round_valid_out = (fsm_q == ST_ROUND);
    bus.round_last_out  = (fsm_q == ST_ROUND) && last_rnd;
    bus.round_data_out  = (fsm_q == ST_ROUND) ? st_q : '0;
    bus.valid_out       = (fsm_q == ST_DONE);
    bus.data_out        = (fsm_q == ST_DONE) ? st_q : '0;
  end

  // Counter was already advanced in KEY_WAIT, so in ROUND it names the next key.
  always_comb begin
    cnt_d  = cnt_q;
    pt_d   = pt_q;
    res_d  = res_q;
    st_d   = st_q;
    addr_d = key_addr;
    if (accept) begin
      pt_d  = bus.data_in;
      cnt_d = '0;
    end
    if (rnd_take) res_d = bus.round_data_in;
    if (fsm_q == ST_KEY_WAIT && !bus.abort_in && ark_vld) begin
      st_d = ark_out;
      if (!last_rnd) cnt_d = cnt_q + KEY_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      pt_q   <= '0;
      res_q  <= '0;
      st_q   <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      pt_q   <= pt_d;
      res_q  <= res_d;
      st_q   <= st_d;
    end
  end
endmodule
